// File: rtl/audio_stream_pkg.sv
// rtl/audio_stream_pkg.sv - shared constants and FSM state type for the stereo packet path
// Purpose: definitions shared by the mono-to-packet converter and the stereo receiver.
// Contents: default sample width, beats per stereo packet, packet FSM state encoding.
package audio_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BEATS_PER_PACKET   = 2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEND_LEFT  = 2'd1,
    ST_SEND_RIGHT = 2'd2
  } pkt_state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - single-clock sample FIFO with occupancy count
// Purpose: buffers mono samples between the strobe input and the packet FSM.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_push, i_push_data write request and data (ignored when full without a pop)
//   i_pop              read request (ignored when empty)
//   o_rd_data          head-of-queue data, valid whenever o_empty is low
//   o_full, o_empty    occupancy flags
//   o_level            current occupancy, 0..DEPTH
module sample_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_push,
  input  logic [DATA_WIDTH-1:0]   i_push_data,
  input  logic                    i_pop,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  w_pop_ok;
  logic                  w_push_ok;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A push into a full FIFO is still legal when the head leaves on the same edge.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/mono_sample_to_packet_converter.sv
// rtl/mono_sample_to_packet_converter.sv - mono sample strobes to two-beat AXI-Stream packets
// Purpose: buffers mono samples and emits each as a left beat then a right beat (TLAST).
// Ports:
//   M_AXIS_ACLK, M_AXIS_ARESET  clock, asynchronous active-high reset
//   mono_sample_valid, mono_sample  single-cycle sample strobe and value
//   M_AXIS_TVALID/TREADY/TDATA/TLAST  AXI-Stream master, all outputs registered
//   sample_overflow  sticky: a sample was dropped on a full FIFO
//   fifo_level       current FIFO occupancy
module mono_sample_to_packet_converter
  import audio_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        M_AXIS_ACLK,
  input  logic                        M_AXIS_ARESET,
  input  logic                        mono_sample_valid,
  input  logic [DATA_WIDTH-1:0]       mono_sample,
  output logic                        M_AXIS_TVALID,
  input  logic                        M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]       M_AXIS_TDATA,
  output logic                        M_AXIS_TLAST,
  output logic                        sample_overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  pkt_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_overflow;

  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_hs;
  logic                  w_pop;

  assign w_hs = r_tvalid && M_AXIS_TREADY;

  // Pop when starting from idle, or back-to-back after the right beat completes.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_SEND_RIGHT) && w_hs));

  sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (M_AXIS_ACLK),
    .i_rst       (M_AXIS_ARESET),
    .i_push      (mono_sample_valid),
    .i_push_data (mono_sample),
    .i_pop       (w_pop),
    .o_rd_data   (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (fifo_level)
  );

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      r_state  <= ST_IDLE;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_tdata  <= w_head;
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_state  <= ST_SEND_LEFT;
          end
        end
        ST_SEND_LEFT: begin
          if (w_hs) begin
            r_tlast <= 1'b1;
            r_state <= ST_SEND_RIGHT;
          end
        end
        ST_SEND_RIGHT: begin
          if (w_hs) begin
            r_tlast <= 1'b0;
            if (!w_empty) begin
              r_tdata <= w_head;
              r_state <= ST_SEND_LEFT;
            end else begin
              r_tvalid <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: begin
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // A drop happens only when full and the head is not leaving on this edge.
  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      r_overflow <= 1'b0;
    end else if (mono_sample_valid && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign M_AXIS_TVALID   = r_tvalid;
  assign M_AXIS_TDATA    = r_tdata;
  assign M_AXIS_TLAST    = r_tlast;
  assign sample_overflow = r_overflow;

endmodule

// File: tb/tb_mono_sample_to_packet_converter.sv
// tb/tb_mono_sample_to_packet_converter.sv - self-checking bench for the mono packet converter
module tb_mono_sample_to_packet_converter;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sv;
  logic [DW-1:0] sd;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          ovf;
  logic [2:0]    lvl;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of accepted samples, the sample currently on the
  // bus, and how many beats of it are still owed (0 = bus idle).
  logic [DW-1:0] m_fifo [$];
  logic [DW-1:0] m_out;
  int            m_beats;
  bit            m_ovf;

  always #5 clk = ~clk;

  mono_sample_to_packet_converter #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .M_AXIS_ACLK       (clk),
    .M_AXIS_ARESET     (rst),
    .mono_sample_valid (sv),
    .mono_sample       (sd),
    .M_AXIS_TVALID     (tvalid),
    .M_AXIS_TREADY     (tready),
    .M_AXIS_TDATA      (tdata),
    .M_AXIS_TLAST      (tlast),
    .sample_overflow   (ovf),
    .fifo_level        (lvl)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_fifo.delete();
    m_out   = '0;
    m_beats = 0;
    m_ovf   = 1'b0;
  endfunction

  function automatic void model_edge(bit v, logic [DW-1:0] d, bit rdy);
    bit hs       = (m_beats > 0) && rdy;
    bit has_data = (m_fifo.size() > 0);
    bit has_room = (m_fifo.size() < DEPTH);
    bit pop      = has_data && ((m_beats == 0) || (m_beats == 1 && hs));
    if (pop) m_out = m_fifo.pop_front();
    if (v) begin
      if (has_room || pop) m_fifo.push_back(d);
      else                 m_ovf = 1'b1;
    end
    if (pop)     m_beats = 2;
    else if (hs) m_beats = m_beats - 1;
  endfunction

  task automatic compare_outputs();
    check("tvalid", {31'b0, tvalid}, {31'b0, (m_beats > 0)});
    check("tlast",  {31'b0, tlast},  {31'b0, (m_beats == 1)});
    if (m_beats > 0) check("tdata", tdata, m_out);
    check("fifo_level", {29'b0, lvl}, DW'(m_fifo.size()));
    check("overflow", {31'b0, ovf}, {31'b0, m_ovf});
  endtask

  // Inputs are driven at the falling edge, the model steps on the rising edge,
  // and outputs are compared at the next falling edge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit rdy);
    sv     = v;
    sd     = d;
    tready = rdy;
    @(posedge clk);
    model_edge(v, d, rdy);
    @(negedge clk);
    compare_outputs();
  endtask

  // Reset is raised mid-cycle so its effect is seen before any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_tvalid", {31'b0, tvalid}, 32'd0);
    check("rst_tlast",  {31'b0, tlast},  32'd0);
    check("rst_tdata",  tdata,           32'd0);
    check("rst_level",  {29'b0, lvl},    32'd0);
    check("rst_ovf",    {31'b0, ovf},    32'd0);
    @(negedge clk);
    sv  = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    sv     = 1'b0;
    sd     = '0;
    tready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_outputs();
    check("reset_tdata", tdata, 32'd0);
    rst = 1'b0;

    // Single sample, sink always ready.
    cyc(1'b1, 32'h0000_1234, 1'b1);
    repeat (4) cyc(1'b0, '0, 1'b1);

    // Two samples two cycles apart: back-to-back packets.
    cyc(1'b1, 32'hA, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 32'hB, 1'b1);
    repeat (5) cyc(1'b0, '0, 1'b1);

    // Left beat held under backpressure for 20+ cycles.
    cyc(1'b1, 32'h55, 1'b0);
    repeat (21) cyc(1'b0, '0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1);

    // Fill while stalled, then one more sample is dropped.
    for (int i = 1; i <= 5; i++) cyc(1'b1, DW'(i), 1'b0);
    cyc(1'b1, 32'd6, 1'b0);
    check("ovf_set", {31'b0, ovf}, 32'd1);
    repeat (12) cyc(1'b0, '0, 1'b1);

    // Write into a full FIFO on the same edge as a right-beat pop.
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, DW'(i), 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 32'd7, 1'b1);
    check("ovf_clear", {31'b0, ovf}, 32'd0);
    repeat (14) cyc(1'b0, '0, 1'b1);

    // Reset while the right beat is on the bus.
    cyc(1'b1, 32'h9, 1'b1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    check("in_right", {31'b0, tlast}, 32'd1);
    do_reset();
    repeat (4) cyc(1'b0, '0, 1'($urandom_range(0, 1)));

    // Random traffic with varying strobe rate and sink readiness.
    for (int blk = 0; blk < 20; blk++) begin
      int pv = $urandom_range(10, 80);
      int pr = $urandom_range(10, 100);
      if (blk % 4 == 3) do_reset();
      for (int c = 0; c < 150; c++)
        cyc($urandom_range(0, 99) < pv, $urandom, $urandom_range(0, 99) < pr);
    end
    repeat (10) cyc(1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mono_sample_to_packet_converter.md
# mono_sample_to_packet_converter

Transmit-side counterpart of the stereo-packet receiver: accepts single-cycle mono sample strobes from the processing pipeline, buffers them in a small FIFO, and emits each as a two-beat AXI-Stream packet (left beat, then right beat carrying TLAST) toward the audio output DMA/codec path. It sits between the visualizer/processing logic and the AXI-Stream output interconnect, and absorbs downstream backpressure up to the FIFO depth.

## Interface
- DATA_WIDTH, 32, width of one sample and of M_AXIS_TDATA
- FIFO_DEPTH, 4, sample buffer entries; power of two, minimum 2
- M_AXIS_ACLK  input  1  single clock for all logic
- M_AXIS_ARESET  input  1  asynchronous, active-high reset
- mono_sample_valid  input  1  single-cycle strobe; mono_sample valid this cycle
- mono_sample  input  DATA_WIDTH  mono sample value
- M_AXIS_TVALID  output  1  AXI-Stream master valid
- M_AXIS_TREADY  input  1  AXI-Stream slave ready
- M_AXIS_TDATA  output  DATA_WIDTH  beat data (same sample on both beats)
- M_AXIS_TLAST  output  1  high on right (second) beat only
- sample_overflow  output  1  sticky; a sample was dropped because FIFO was full
- fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Reset (async, M_AXIS_ARESET=1): FIFO empty, fifo_level=0, state Idle, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, sample_overflow=0. Outputs take reset values immediately, not at next edge; a packet in flight is abandoned, no partial beats resume after reset.
- Input side: no backpressure to producer. On an edge with mono_sample_valid=1: write to FIFO if not full; if full and no pop on the same edge, drop sample and set sample_overflow (cleared only by reset). Simultaneous write+pop when full: both occur, level unchanged, no overflow.
- FSM states: Idle, SendLeft, SendRight.
  - Idle: if FIFO non-empty, pop head into TDATA register, TVALID=1, TLAST=0 -> SendLeft.
  - SendLeft: hold TDATA/TVALID stable; on TVALID&&TREADY, TLAST=1 -> SendRight.
  - SendRight: hold; on TVALID&&TREADY: if FIFO non-empty pop next into TDATA, TLAST=0 -> SendLeft (no bubble); else TVALID=0, TLAST=0 -> Idle.
- AXI rules: TVALID never depends combinationally on TREADY; once high, TVALID/TDATA/TLAST stable until handshake. All outputs are registers.
- TDATA passes the sample unmodified; no arithmetic. Both beats carry identical data.
- fifo_level = writes - pops since reset, range 0..FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.

## Timing
- Latency: strobe sampled at edge E0 (write), FIFO visible non-empty after E0, Idle pops at E1; TVALID high after E1 (one cycle after write edge, two clocks from strobe assertion).
- Max throughput: one packet (2 beats) per 2 cycles with TREADY held high; sustained strobe rate above 1/2 eventually overflows.
- TREADY low holds current beat indefinitely; FIFO keeps accepting until full.
- TREADY toggling between beats: each beat advances only on its own handshake edge.

## Structure
- Shared package/include audio_stream_pkg: FSM state localparams (Idle, SendLeft, SendRight), default DATA_WIDTH, beat-count constant (2 beats per stereo packet) shared with the receiver.
- One sub-module: sample_fifo (synchronous single-clock FIFO, DATA_WIDTH x FIFO_DEPTH, push/pop/full/empty/level, async active-high reset). Converter holds FSM and output registers.

## Test plan
- Single strobe 0x0000_1234, TREADY=1 -> TVALID rises after next edge; beats 0x0000_1234/TLAST=0 then 0x0000_1234/TLAST=1; TVALID low afterward; fifo_level returns 0.
- Strobes 0xA, 0xB on consecutive-but-2-apart cycles, TREADY=1 -> beats A,A(L),B,B(L) with no idle cycle between packets.
- TREADY=0 for 20 cycles during SendLeft with 0x55 held -> TVALID, TDATA=0x55, TLAST=0 stable all 20 cycles; packet completes after TREADY=1.
- TREADY=0, 5 strobes 1..5 with FIFO_DEPTH=4 -> first popped into output register, 2..5 fill FIFO, no overflow; 6th strobe -> sample_overflow=1, sample 6 never appears; releasing TREADY yields packets 1..5 in order.
- Full FIFO, strobe on same edge as a SendRight handshake pop -> sample accepted, sample_overflow stays 0.
- Assert M_AXIS_ARESET mid SendRight -> TVALID, TLAST, TDATA go 0 asynchronously; after release with no strobes TVALID stays 0, fifo_level=0.
